// File: rtl/pwm_duty_ramp_ctrl.sv
// PWM duty sequencer: accepts target duty requests and ramps duty_out one step per
// STEP_PERIODS counted PWM periods. Define PWM_RAMP_RETARGET_EN to accept new targets mid-ramp.
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W       = 4,
  parameter int DUTY_MAX     = 10,
  parameter int DUTY_INIT    = 5,
  parameter int STEP_PERIODS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              period_start,
  input  logic              ramp_hold,
  input  logic              req_valid,
  input  logic [DUTY_W-1:0] req_target,
  output logic              req_ready,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_PERIODS - 1);
  localparam logic [DUTY_W-1:0] MAX_V    = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_V   = DUTY_W'(DUTY_INIT);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t            state;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] req_clamped;
  logic [DUTY_W-1:0] step_duty;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              tick;
  logic              step;

`ifdef PWM_RAMP_RETARGET_EN
  assign req_ready = 1'b1;
`else
  assign req_ready = (state == IDLE);
`endif

  // step_duty is the duty value that will be visible after this edge
  always_comb begin
    req_clamped = (req_target > MAX_V) ? MAX_V : req_target;
    accept      = req_valid && req_ready;
    tick        = (state == RAMP) && period_start && !ramp_hold;
    step        = tick && (cnt == CNT_LAST);
    step_duty   = duty_out;
    if (step) begin
      step_duty = (target > duty_out) ? duty_out + 1'b1 : duty_out - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_out <= INIT_V;
      target   <= INIT_V;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      duty_out <= step_duty;
      if (tick) begin
        cnt <= step ? '0 : cnt + 1'b1;
      end
      if (state == IDLE) begin
        if (accept) begin
          target <= req_clamped;
          cnt    <= '0;
          if (req_clamped == duty_out) begin
            done <= 1'b1;
          end else begin
            state <= RAMP;
            busy  <= 1'b1;
          end
        end
      end else begin
        if (step && (step_duty == target)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
`ifdef PWM_RAMP_RETARGET_EN
        // A same-edge step already used the old target; completion is judged on the new one
        if (accept) begin
          target <= req_clamped;
          if (req_clamped == step_duty) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RAMP;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Self-checking bench for pwm_duty_ramp_ctrl: vector table plus hand-written reset and retarget
// sequences, with expected outputs queued per driven cycle.
module tb_pwm_duty_ramp_ctrl;

  typedef struct packed {
    logic [3:0] duty;
    logic       busy;
    logic       done;
    logic       ready;
  } outs_t;

  typedef struct {
    int         gap;
    logic       ps;
    logic       hold;
    logic       valid;
    logic [3:0] tgt;
    outs_t      exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       period_start;
  logic       ramp_hold;
  logic       req_valid;
  logic [3:0] req_target;
  logic       req_ready;
  logic [3:0] duty_out;
  logic       busy;
  logic       done;

  int    total;
  int    bad;
  vec_t  vecs[$];
  outs_t sbq[$];
  outs_t cur;

  pwm_duty_ramp_ctrl #(
    .DUTY_W(4), .DUTY_MAX(10), .DUTY_INIT(5), .STEP_PERIODS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .period_start(period_start),
    .ramp_hold(ramp_hold),
    .req_valid(req_valid),
    .req_target(req_target),
    .req_ready(req_ready),
    .duty_out(duty_out),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(input logic [3:0] d, input logic b, input logic dn);
    outs_t o;
    o.duty = d;
    o.busy = b;
    o.done = dn;
`ifdef PWM_RAMP_RETARGET_EN
    o.ready = 1'b1;
`else
    o.ready = !b;
`endif
    return o;
  endfunction

  function automatic void add(input int gap, input logic ps, input logic hold, input logic valid,
                              input logic [3:0] tgt, input logic [3:0] d, input logic b,
                              input logic dn);
    vec_t v;
    v.gap   = gap;
    v.ps    = ps;
    v.hold  = hold;
    v.valid = valid;
    v.tgt   = tgt;
    v.exp   = mk(d, b, dn);
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name);
    outs_t exp;
    outs_t act;
    act = {duty_out, busy, done, req_ready};
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: no expected entry queued, got duty=%0d", name, duty_out);
    end else begin
      exp = sbq.pop_front();
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL %s: got duty=%0d busy=%b done=%b ready=%b, want duty=%0d busy=%b done=%b ready=%b",
                 name, act.duty, act.busy, act.done, act.ready, exp.duty, exp.busy, exp.done, exp.ready);
      end
    end
    total++;
    if (duty_out > 4'd10) begin
      bad++;
      $display("[TB] FAIL %s_range: got duty=%0d, want <= 10", name, duty_out);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, and compare just after the edge
  task automatic applyStimulus(input logic ps, input logic hold, input logic valid,
                               input logic [3:0] tgt, input outs_t exp, input string name);
    @(negedge clk);
    period_start = ps;
    ramp_hold    = hold;
    req_valid    = valid;
    req_target   = tgt;
    sbq.push_back(exp);
    @(posedge clk);
    #1;
    checkOutput(name);
    cur      = exp;
    cur.done = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic hold, input string name);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, hold, 1'b0, 4'd0, cur, name);
    end
  endtask

  initial begin
    int rt_seq[10];
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    period_start = 1'b0;
    ramp_hold    = 1'b0;
    req_valid    = 1'b0;
    req_target   = 4'd0;
    cur          = mk(4'd5, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, mk(4'd5, 1'b0, 1'b0), "reset");
    rst_n = 1'b1;

    // Idle, then ramp 5->8 with a same-cycle period_start on the accept
    add(19, 0, 0, 0, 4'd0, 4'd5, 0, 0);
    add(0,  1, 0, 1, 4'd8, 4'd5, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd5, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd6, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd6, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd7, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd7, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd8, 0, 1);
    add(3,  0, 0, 0, 4'd0, 4'd8, 0, 0);
    // Request 15 clamps to 10
    add(0,  0, 0, 1, 4'd15, 4'd8, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd8, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd9, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd9, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd10, 0, 1);
    add(2,  0, 0, 0, 4'd0, 4'd10, 0, 0);
    // Ramp 10 down to 0
    add(0,  0, 0, 1, 4'd0, 4'd10, 1, 0);
`ifndef PWM_RAMP_RETARGET_EN
    add(4,  0, 0, 1, 4'd3, 4'd10, 1, 0);
`endif
    for (int d = 9; d >= 0; d--) begin
      add(9, 1, 0, 0, 4'd0, 4'(d + 1), 1, 0);
      add(9, 1, 0, 0, 4'd0, 4'(d), d != 0, d == 0);
    end
    add(9,  1, 0, 0, 4'd0, 4'd0, 0, 0);
    add(9,  1, 0, 0, 4'd0, 4'd0, 0, 0);
    // Back up to 5, then request the current value
    add(0,  0, 0, 1, 4'd5, 4'd0, 1, 0);
    for (int d = 0; d < 5; d++) begin
      add(9, 1, 0, 0, 4'd0, 4'(d), 1, 0);
      add(9, 1, 0, 0, 4'd0, 4'(d + 1), d != 4, d == 4);
    end
    add(1,  0, 0, 0, 4'd0, 4'd5, 0, 0);
    add(0,  0, 0, 1, 4'd5, 4'd5, 0, 1);
    add(0,  0, 0, 0, 4'd0, 4'd5, 0, 0);
    add(3,  0, 0, 0, 4'd0, 4'd5, 0, 0);
    // ramp_hold keeps the partial count across three ignored pulses
    add(0,  0, 0, 1, 4'd8, 4'd5, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd5, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd6, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd6, 1, 0);
    add(9,  1, 1, 0, 4'd0, 4'd6, 1, 0);
    add(9,  1, 1, 0, 4'd0, 4'd6, 1, 0);
    add(9,  1, 1, 0, 4'd0, 4'd6, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd7, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd7, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd8, 0, 1);
    // Step down to 7 ready for the reset sequence
    add(2,  0, 0, 0, 4'd0, 4'd8, 0, 0);
    add(0,  0, 0, 1, 4'd7, 4'd8, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd8, 1, 0);
    add(9,  1, 0, 0, 4'd0, 4'd7, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      idleCycles(vecs[i].gap, vecs[i].hold, $sformatf("vec%0d_gap", i));
      applyStimulus(vecs[i].ps, vecs[i].hold, vecs[i].valid, vecs[i].tgt, vecs[i].exp,
                    $sformatf("vec%0d", i));
    end

    // Reset mid-ramp 7->9: duty returns to 5, no done, no further stepping
    idleCycles(2, 1'b0, "pre_rst_idle");
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd9, mk(4'd7, 1'b1, 1'b0), "rst_acc9");
    idleCycles(9, 1'b0, "rst_gap");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, mk(4'd7, 1'b1, 1'b0), "rst_pulse");
    idleCycles(3, 1'b0, "rst_gap2");
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, mk(4'd5, 1'b0, 1'b0), "rst_mid");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idleCycles(9, 1'b0, "post_rst_gap");
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, mk(4'd5, 1'b0, 1'b0), $sformatf("post_rst%0d", k));
    end

`ifdef PWM_RAMP_RETARGET_EN
    // Retarget from 9 to 2 while at duty 7
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd9, mk(4'd5, 1'b1, 1'b0), "rt_acc9");
    idleCycles(9, 1'b0, "rt_gap");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, mk(4'd5, 1'b1, 1'b0), "rt_up0");
    idleCycles(9, 1'b0, "rt_gap");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, mk(4'd6, 1'b1, 1'b0), "rt_up1");
    idleCycles(9, 1'b0, "rt_gap");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, mk(4'd6, 1'b1, 1'b0), "rt_up2");
    idleCycles(9, 1'b0, "rt_gap");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, mk(4'd7, 1'b1, 1'b0), "rt_up3");
    idleCycles(2, 1'b0, "rt_gap");
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, mk(4'd7, 1'b1, 1'b0), "rt_acc2");
    rt_seq = '{7, 6, 6, 5, 5, 4, 4, 3, 3, 2};
    for (int i = 0; i < 10; i++) begin
      idleCycles(9, 1'b0, "rt_gap");
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, mk(4'(rt_seq[i]), i != 9, i == 9),
                    $sformatf("rt_down%0d", i));
    end
    idleCycles(2, 1'b0, "rt_tail");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
